// File: rtl/alu_exec_if.sv
// alu_exec_if: issue-side and writeback-side handshake bundle of one ALU execute lane
interface alu_exec_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6,
    parameter int OP_W  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [WIDTH-1:0] in_rs1;
    logic [WIDTH-1:0] in_rs2;
    logic [WIDTH-1:0] in_imm;
    logic             in_use_imm;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_br_taken;
    logic             out_is_br;
    logic [TAG_W-1:0] out_tag;
    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_imm, in_use_imm, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_br_taken, out_is_br, out_tag
    );
    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_imm, in_use_imm, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_br_taken, out_is_br, out_tag
    );
endinterface

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: ALU execute lane with Kogge-Stone adder and a 2-entry skid buffer to writeback
module alu_ks_adder (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum
);
    logic [31:0] w_g [0:5];
    logic [31:0] w_p [0:5];
    assign w_p[0] = i_a ^ i_b;
    assign w_g[0] = (i_a & i_b) | {31'b0, w_p[0][0] & i_cin};
    genvar l, i;
    for (l = 0; l < 5; l++) begin : g_lvl
        for (i = 0; i < 32; i++) begin : g_bit
            if (i >= (1 << l)) begin : g_op
                assign w_g[l+1][i] = w_g[l][i] | (w_p[l][i] & w_g[l][i-(1<<l)]);
                assign w_p[l+1][i] = w_p[l][i] & w_p[l][i-(1<<l)];
            end else begin : g_cp
                assign w_g[l+1][i] = w_g[l][i];
                assign w_p[l+1][i] = w_p[l][i];
            end
        end
    end
    assign o_sum = w_p[0] ^ {w_g[5][30:0], i_cin};
endmodule

module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6,
    parameter int OP_W  = 4
) (
    input logic       i_clk,
    input logic       i_rst_n,
    input logic       i_flush,
    alu_exec_if.slave bus
);
    localparam logic [OP_W-1:0] OP_ADD = 0, OP_SUB = 1, OP_SLT = 2, OP_SLTU = 3, OP_BEQ = 4,
        OP_BNE = 5, OP_BLT = 6, OP_BGE = 7, OP_BLTU = 8, OP_BGEU = 9, OP_PASSB = 10;
    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             br;
        logic             is_br;
        logic [TAG_W-1:0] tag;
    } entry_t;
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;
    state_t           r_state, w_state;
    entry_t           r_e0, r_e1, w_new;
    logic [OP_W-1:0]  w_op;
    logic [WIDTH-1:0] w_a, w_b, w_sum;
    logic             w_sub, w_eq, w_slt, w_sltu, w_push, w_pop;
    assign w_op   = bus.in_op;
    assign w_a    = bus.in_rs1;
    assign w_b    = (bus.in_use_imm && (w_op == OP_ADD || w_op == OP_SLT || w_op == OP_SLTU
                    || w_op == OP_PASSB)) ? bus.in_imm : bus.in_rs2;
    assign w_sub  = !(w_op == OP_ADD || w_op == OP_PASSB);
    alu_ks_adder u_add (
        .i_a   (w_a),
        .i_b   (w_sub ? ~w_b : w_b),
        .i_cin (w_sub),
        .o_sum (w_sum)
    );
    assign w_eq   = (w_sum == '0);
    assign w_slt  = (w_a[WIDTH-1] ^ w_b[WIDTH-1]) ? w_a[WIDTH-1] : w_sum[WIDTH-1];
    assign w_sltu = (w_a[WIDTH-1] ^ w_b[WIDTH-1]) ? w_b[WIDTH-1] : w_sum[WIDTH-1];
    always_comb begin
        w_new       = '0;
        w_new.tag   = bus.in_tag;
        w_new.is_br = (w_op >= OP_BEQ) && (w_op <= OP_BGEU);
        w_new.res   = (w_op == OP_ADD || w_op == OP_SUB) ? w_sum :
                      w_op == OP_SLT   ? {{(WIDTH-1){1'b0}}, w_slt} :
                      w_op == OP_SLTU  ? {{(WIDTH-1){1'b0}}, w_sltu} :
                      w_op == OP_PASSB ? w_b : '0;
        w_new.br    = w_op == OP_BEQ  ? w_eq :
                      w_op == OP_BNE  ? !w_eq :
                      w_op == OP_BLT  ? w_slt :
                      w_op == OP_BGE  ? !w_slt :
                      w_op == OP_BLTU ? w_sltu :
                      w_op == OP_BGEU ? !w_sltu : 1'b0;
    end
    assign bus.in_ready     = (r_state != S_FULL);
    assign bus.out_valid    = (r_state != S_EMPTY);
    assign bus.out_result   = r_e0.res;
    assign bus.out_br_taken = r_e0.br;
    assign bus.out_is_br    = r_e0.is_br;
    assign bus.out_tag      = r_e0.tag;
    assign w_push = bus.in_valid && bus.in_ready;
    assign w_pop  = bus.out_valid && bus.out_ready;
    always_comb begin
        w_state = r_state;
        w_state = i_flush ? S_EMPTY :
                  r_state == S_EMPTY ? (w_push ? S_ONE : S_EMPTY) :
                  r_state == S_ONE ? ((w_push && !w_pop) ? S_FULL :
                                      (!w_push && w_pop) ? S_EMPTY : S_ONE) :
                  (w_pop ? S_ONE : S_FULL);
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_EMPTY;
        else          r_state <= w_state;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_e0 <= '0;
            r_e1 <= '0;
        end else if (!i_flush) begin
            if (w_pop && r_state == S_FULL) r_e0 <= r_e1;
            else if (w_push && (r_state == S_EMPTY || w_pop)) r_e0 <= w_new;
            if (w_push && r_state == S_ONE && !w_pop) r_e1 <= w_new;
        end
    end
endmodule
